// File: rtl/cmd_timer_pkg.sv
// rtl/cmd_timer_pkg.sv - command codes, timing-register indices and load helper for command_timer_param
package cmd_timer_pkg;

    localparam int DEC_DDR_CMD_SZ = 3;
    localparam int NUM_T_REGS     = 12;
    localparam int OFF_W          = $clog2(4);
    localparam int BANK_W         = $clog2(8);

    typedef enum logic [DEC_DDR_CMD_SZ-1:0] {
        CMD_NOP     = 3'd0,
        CMD_ACT     = 3'd1,
        CMD_PRE     = 3'd2,
        CMD_PRE_ALL = 3'd3,
        CMD_READ    = 3'd4,
        CMD_WRITE   = 3'd5,
        CMD_REF     = 3'd6,
        CMD_ZQS     = 3'd7
    } cmd_e;

    typedef enum logic [3:0] {
        IDX_RCD = 4'd0,
        IDX_RP  = 4'd1,
        IDX_RAS = 4'd2,
        IDX_RC  = 4'd3,
        IDX_RTP = 4'd4,
        IDX_WR  = 4'd5,
        IDX_RRD = 4'd6,
        IDX_CCD = 4'd7,
        IDX_RFC = 4'd8,
        IDX_FAW = 4'd9,
        IDX_WTR = 4'd10,
        IDX_RTW = 4'd11
    } t_idx_e;

    // Remaining DDR clocks after the current fabric cycle, clamped at zero.
    function automatic int sat_load(input int s, input int t, input int nck);
        int v;
        v = s + t - nck;
        return (v < 0) ? 0 : v;
    endfunction

endpackage

// File: rtl/remaining_counter.sv
// rtl/remaining_counter.sv - one remaining-DDR-clocks counter with max-merge load
module remaining_counter
    import cmd_timer_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int NCK   = 4,
    parameter int OW    = OFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             sat,
    output logic [OW-1:0]    slot
);

    localparam logic [CNT_W-1:0] NCK_C = CNT_W'(NCK);

    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] dec;

    always_comb begin
        dec = (r >= NCK_C) ? r - NCK_C : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (load && (load_val > dec)) begin
            r <= load_val;
        end else begin
            r <= dec;
        end
    end

    assign sat  = (r < NCK_C);
    assign slot = r[OW-1:0];

endmodule

// File: rtl/command_timer_param.sv
// rtl/command_timer_param.sv - per-command DDR timing checker with programmable timings and tFAW window
module command_timer_param
    import cmd_timer_pkg::*;
#(
    parameter int NUM_BANKS   = 8,
    parameter int nCK_PER_CLK = 4,
    parameter int CNT_W       = 8,
    parameter int T_RCD       = 11,
    parameter int T_RP        = 11,
    parameter int T_RAS       = 28,
    parameter int T_RC        = 39,
    parameter int T_RTP       = 6,
    parameter int T_WR        = 12,
    parameter int T_RRD       = 5,
    parameter int T_CCD       = 4,
    parameter int T_RFC       = 128,
    parameter int T_FAW       = 24,
    parameter int T_WTR       = 6,
    parameter int T_RTW       = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DEC_DDR_CMD_SZ-1:0]         cmd,
    input  logic [$clog2(NUM_BANKS)-1:0]      bank,
    input  logic                              issue,
    input  logic [$clog2(nCK_PER_CLK)-1:0]    new_issue_offset,
    output logic [$clog2(nCK_PER_CLK)-1:0]    offset,
    output logic                              valid,
    input  logic                              cfg_we,
    input  logic [3:0]                        cfg_sel,
    input  logic [CNT_W-1:0]                  cfg_val,
    output logic                              violation
);

    localparam int OW = $clog2(nCK_PER_CLK);
    localparam int BW = $clog2(NUM_BANKS);

    localparam logic [CNT_W-1:0] T_DEF [NUM_T_REGS] = '{
        CNT_W'(T_RCD), CNT_W'(T_RP),  CNT_W'(T_RAS), CNT_W'(T_RC),
        CNT_W'(T_RTP), CNT_W'(T_WR),  CNT_W'(T_RRD), CNT_W'(T_CCD),
        CNT_W'(T_RFC), CNT_W'(T_FAW), CNT_W'(T_WTR), CNT_W'(T_RTW)
    };

    logic [CNT_W-1:0] t_reg [NUM_T_REGS];
    logic [CNT_W-1:0] l_val [NUM_T_REGS];
    logic [1:0]       faw_ptr;

    logic is_act, is_pre, is_pre_all, is_rd, is_wr, is_ref;
    logic [NUM_BANKS-1:0] hit, ld_act, ld_rp, ld_rd, ld_wr;

    logic [NUM_BANKS-1:0] rcd_sat, rp_sat, ras_sat, rc_sat, rtp_sat, wr_sat;
    logic [OW-1:0] rcd_slot [NUM_BANKS];
    logic [OW-1:0] rp_slot  [NUM_BANKS];
    logic [OW-1:0] ras_slot [NUM_BANKS];
    logic [OW-1:0] rc_slot  [NUM_BANKS];
    logic [OW-1:0] rtp_slot [NUM_BANKS];
    logic [OW-1:0] wr_slot  [NUM_BANKS];

    logic rrd_sat, ccd_sat, rfc_sat, wtr_sat, rtw_sat;
    logic [OW-1:0] rrd_slot, ccd_slot, rfc_slot, wtr_slot, rtw_slot;
    logic [3:0] faw_sat, faw_ld;
    logic [OW-1:0] faw_slot [4];

    logic          ok;
    logic [OW-1:0] off;

    function automatic logic [OW-1:0] omax(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_T_REGS; i++) t_reg[i] <= T_DEF[i];
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_T_REGS; i++) begin
                if (cfg_sel == 4'(i)) t_reg[i] <= cfg_val;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_T_REGS; k++) begin
            l_val[k] = CNT_W'(sat_load(int'(new_issue_offset), int'(t_reg[k]), nCK_PER_CLK));
        end
    end

    always_comb begin
        is_act     = issue && (cmd == CMD_ACT);
        is_pre     = issue && (cmd == CMD_PRE);
        is_pre_all = issue && (cmd == CMD_PRE_ALL);
        is_rd      = issue && (cmd == CMD_READ);
        is_wr      = issue && (cmd == CMD_WRITE);
        is_ref     = issue && (cmd == CMD_REF);
        for (int i = 0; i < NUM_BANKS; i++) begin
            hit[i]    = (bank == BW'(i));
            ld_act[i] = is_act && hit[i];
            ld_rp[i]  = (is_pre && hit[i]) || is_pre_all;
            ld_rd[i]  = is_rd && hit[i];
            ld_wr[i]  = is_wr && hit[i];
        end
        for (int j = 0; j < 4; j++) begin
            faw_ld[j] = is_act && (faw_ptr == 2'(j));
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rcd (
            .clk(clk), .rst(rst), .load(ld_act[i]), .load_val(l_val[IDX_RCD]),
            .sat(rcd_sat[i]), .slot(rcd_slot[i]));
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_ras (
            .clk(clk), .rst(rst), .load(ld_act[i]), .load_val(l_val[IDX_RAS]),
            .sat(ras_sat[i]), .slot(ras_slot[i]));
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rc (
            .clk(clk), .rst(rst), .load(ld_act[i]), .load_val(l_val[IDX_RC]),
            .sat(rc_sat[i]), .slot(rc_slot[i]));
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rp (
            .clk(clk), .rst(rst), .load(ld_rp[i]), .load_val(l_val[IDX_RP]),
            .sat(rp_sat[i]), .slot(rp_slot[i]));
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rtp (
            .clk(clk), .rst(rst), .load(ld_rd[i]), .load_val(l_val[IDX_RTP]),
            .sat(rtp_sat[i]), .slot(rtp_slot[i]));
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_wr (
            .clk(clk), .rst(rst), .load(ld_wr[i]), .load_val(l_val[IDX_WR]),
            .sat(wr_sat[i]), .slot(wr_slot[i]));
    end

    remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rrd (
        .clk(clk), .rst(rst), .load(is_act || is_pre || is_pre_all || is_ref),
        .load_val(l_val[IDX_RRD]), .sat(rrd_sat), .slot(rrd_slot));
    remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_ccd (
        .clk(clk), .rst(rst), .load(is_rd || is_wr),
        .load_val(l_val[IDX_CCD]), .sat(ccd_sat), .slot(ccd_slot));
    remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rfc (
        .clk(clk), .rst(rst), .load(is_ref),
        .load_val(l_val[IDX_RFC]), .sat(rfc_sat), .slot(rfc_slot));
    remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_wtr (
        .clk(clk), .rst(rst), .load(is_wr),
        .load_val(l_val[IDX_WTR]), .sat(wtr_sat), .slot(wtr_slot));
    remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_rtw (
        .clk(clk), .rst(rst), .load(is_rd),
        .load_val(l_val[IDX_RTW]), .sat(rtw_sat), .slot(rtw_slot));

    // tFAW: a ring of four windows; each ACT reuses the oldest one.
    for (genvar j = 0; j < 4; j++) begin : g_faw
        remaining_counter #(.CNT_W(CNT_W), .NCK(nCK_PER_CLK), .OW(OW)) u_faw (
            .clk(clk), .rst(rst), .load(faw_ld[j]),
            .load_val(l_val[IDX_FAW]), .sat(faw_sat[j]), .slot(faw_slot[j]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            faw_ptr   <= 2'd0;
            violation <= 1'b0;
        end else begin
            if (is_act) faw_ptr <= faw_ptr + 2'd1;
            if (issue && !ok) violation <= 1'b1;
        end
    end

    always_comb begin
        ok  = 1'b1;
        off = '0;
        case (cmd)
            CMD_ACT: begin
                ok  = rp_sat[bank] && rc_sat[bank] && rrd_sat && rfc_sat && faw_sat[faw_ptr];
                off = omax(omax(rp_slot[bank], rc_slot[bank]),
                           omax(omax(rrd_slot, rfc_slot), faw_slot[faw_ptr]));
            end
            CMD_PRE: begin
                ok  = ras_sat[bank] && wr_sat[bank] && rtp_sat[bank] && rrd_sat;
                off = omax(omax(ras_slot[bank], wr_slot[bank]), omax(rtp_slot[bank], rrd_slot));
            end
            CMD_PRE_ALL: begin
                ok  = rrd_sat;
                off = rrd_slot;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    ok  = ok && ras_sat[i] && wr_sat[i] && rtp_sat[i];
                    off = omax(off, omax(ras_slot[i], omax(wr_slot[i], rtp_slot[i])));
                end
            end
            CMD_READ: begin
                ok  = rcd_sat[bank] && ccd_sat && wtr_sat;
                off = omax(rcd_slot[bank], omax(ccd_slot, wtr_slot));
            end
            CMD_WRITE: begin
                ok  = rcd_sat[bank] && ccd_sat && rtw_sat;
                off = omax(rcd_slot[bank], omax(ccd_slot, rtw_slot));
            end
            CMD_REF: begin
                ok  = rfc_sat;
                off = rfc_slot;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    ok  = ok && rp_sat[i];
                    off = omax(off, rp_slot[i]);
                end
            end
            default: begin
                ok  = 1'b1;
                off = '0;
            end
        endcase
    end

    assign valid  = ok;
    assign offset = off;

endmodule
